// File: rtl/alu16.sv
// 16-bit ALU: combinational operation decode feeding one registered result/status word.
// Result td and status PSW = {C, Z, V} appear one rising edge after the operands are sampled.
`timescale 1ns/1ps

module alu16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       Opcode,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    input  logic [3:0]       Opcode_src3,
    output logic [WIDTH-1:0] td,
    output logic [2:0]       PSW
);

    // Interface timing: there is no valid/ready pair. Every rising edge with
    // rst low accepts a new operation, and its result is visible after that edge.
    // td/PSW hold between edges. rst clears them at once, independent of clk.

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_ROL  = 4'd9;
    localparam logic [3:0] OP_ROR  = 4'd10;
    localparam logic [3:0] OP_INC  = 4'd11;
    localparam logic [3:0] OP_DEC  = 4'd12;
    localparam logic [3:0] OP_SLT  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_PASS = 4'd15;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sll_ext;
    logic [WIDTH:0]     srl_ext;
    logic [WIDTH:0]     sra_ext;
    logic [4:0]         rot_inv;
    logic [WIDTH-1:0]   rol_r;
    logic [WIDTH-1:0]   ror_r;
    logic               add_v;
    logic               sub_v;
    logic [WIDTH-1:0]   res;
    logic               c;
    logic               v;
    logic [WIDTH+2:0]   out_q;

    // INC/DEC share the ADD/SUB adders with the second operand forced to 1.
    assign add_b = (Opcode == OP_INC || Opcode == OP_DEC) ? WIDTH'(1) : alu_src2;
    assign sum   = {1'b0, alu_src1} + {1'b0, add_b};
    assign diff  = {1'b0, alu_src1} - {1'b0, add_b};
    assign prod  = {{WIDTH{1'b0}}, alu_src1} * {{WIDTH{1'b0}}, alu_src2};

    assign add_v = (alu_src1[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != alu_src1[WIDTH-1]);
    assign sub_v = (alu_src1[WIDTH-1] != add_b[WIDTH-1]) && (diff[WIDTH-1] != alu_src1[WIDTH-1]);

    // Shifts carry one guard bit so the last bit shifted out lands in it (zero when s=0).
    assign sll_ext = {1'b0, alu_src1} << Opcode_src3;
    assign srl_ext = {alu_src1, 1'b0} >> Opcode_src3;
    assign sra_ext = $signed({alu_src1, 1'b0}) >>> Opcode_src3;

    assign rot_inv = 5'(WIDTH) - {1'b0, Opcode_src3};
    assign rol_r   = (alu_src1 << Opcode_src3) | (alu_src1 >> rot_inv);
    assign ror_r   = (alu_src1 >> Opcode_src3) | (alu_src1 << rot_inv);

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (Opcode)
            OP_ADD, OP_INC: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = add_v;
            end
            OP_SUB, OP_DEC: begin
                res = diff[WIDTH-1:0];
                c   = diff[WIDTH];
                v   = sub_v;
            end
            OP_AND:  res = alu_src1 & alu_src2;
            OP_OR:   res = alu_src1 | alu_src2;
            OP_XOR:  res = alu_src1 ^ alu_src2;
            OP_NOT:  res = ~alu_src1;
            OP_SLL: begin
                res = sll_ext[WIDTH-1:0];
                c   = sll_ext[WIDTH];
            end
            OP_SRL: begin
                res = srl_ext[WIDTH:1];
                c   = srl_ext[0];
            end
            OP_SRA: begin
                res = sra_ext[WIDTH:1];
                c   = sra_ext[0];
            end
            OP_ROL: begin
                res = rol_r;
                c   = (Opcode_src3 != 4'd0) && rol_r[0];
            end
            OP_ROR: begin
                res = ror_r;
                c   = (Opcode_src3 != 4'd0) && ror_r[WIDTH-1];
            end
            OP_SLT: begin
                res = ($signed(alu_src1) < $signed(alu_src2)) ? WIDTH'(1) : '0;
                c   = diff[WIDTH];
            end
            OP_MUL: begin
                res = prod[WIDTH-1:0];
                c   = |prod[2*WIDTH-1:WIDTH];
            end
            OP_PASS: res = alu_src2;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= {c, (res == '0), v, res};
        end
    end

    assign {PSW, td} = out_q;

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed vectors, reset behaviour and a random stream,
// with a queue-based scoreboard popped by an independent monitor after each edge.
`timescale 1ns/1ps

module tb_alu16;

    logic        clk;
    logic        rst;
    logic [3:0]  Opcode;
    logic [15:0] alu_src1;
    logic [15:0] alu_src2;
    logic [3:0]  Opcode_src3;
    logic [15:0] td;
    logic [2:0]  PSW;

    logic [18:0] exp_q[$];
    logic [3:0]  op_q[$];
    int          checks;
    int          errors;

    alu16 dut (
        .clk         (clk),
        .rst         (rst),
        .Opcode      (Opcode),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .Opcode_src3 (Opcode_src3),
        .td          (td),
        .PSW         (PSW)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [18:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] s);
        logic [15:0] r;
        logic        c;
        logic        v;
        logic [31:0] p;
        int          sa;
        int          sb;
        int          t;
        sa = $signed(a);
        sb = $signed(b);
        r  = 16'h0000;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            4'd0: begin
                r = a + b;
                c = ({16'h0000, a} + {16'h0000, b}) > 32'h0000_FFFF;
                t = sa + sb;
                v = (t > 32767) || (t < -32768);
            end
            4'd1: begin
                r = a - b;
                c = a < b;
                t = sa - sb;
                v = (t > 32767) || (t < -32768);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin
                r = a;
                for (int i = 0; i < int'(s); i++) begin c = r[15]; r = {r[14:0], 1'b0}; end
            end
            4'd7: begin
                r = a;
                for (int i = 0; i < int'(s); i++) begin c = r[0]; r = {1'b0, r[15:1]}; end
            end
            4'd8: begin
                r = a;
                for (int i = 0; i < int'(s); i++) begin c = r[0]; r = {r[15], r[15:1]}; end
            end
            4'd9: begin
                r = a;
                for (int i = 0; i < int'(s); i++) r = {r[14:0], r[15]};
                c = (s != 4'd0) ? r[0] : 1'b0;
            end
            4'd10: begin
                r = a;
                for (int i = 0; i < int'(s); i++) r = {r[0], r[15:1]};
                c = (s != 4'd0) ? r[15] : 1'b0;
            end
            4'd11: begin
                r = a + 16'h0001;
                c = (a == 16'hFFFF);
                v = (a == 16'h7FFF);
            end
            4'd12: begin
                r = a - 16'h0001;
                c = (a == 16'h0000);
                v = (a == 16'h8000);
            end
            4'd13: begin
                r = (sa < sb) ? 16'h0001 : 16'h0000;
                c = a < b;
            end
            4'd14: begin
                p = {16'h0000, a} * {16'h0000, b};
                r = p[15:0];
                c = p > 32'h0000_FFFF;
            end
            default: r = b;
        endcase
        return {c, (r == 16'h0000), v, r};
    endfunction

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [18:0] got, input logic [18:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got PSW=%b td=%h, expected PSW=%b td=%h",
                     name, got[18:16], got[15:0], want[18:16], want[15:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [3:0] s);
        Opcode      = op;
        alu_src1    = a;
        alu_src2    = b;
        Opcode_src3 = s;
    endtask

    task automatic randomize_inputs();
        set_inputs(4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)),
                   16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
    endtask

    // Directed vector: expected value is hand-computed by the caller.
    task automatic dir(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input logic [2:0] psw, input logic [15:0] res);
        @(negedge clk);
        set_inputs(op, a, b, s);
        exp_q.push_back({psw, res});
        op_q.push_back(op);
    endtask

    task automatic rnd_op();
        @(negedge clk);
        randomize_inputs();
        exp_q.push_back(model(Opcode, alu_src1, alu_src2, Opcode_src3));
        op_q.push_back(Opcode);
    endtask

    // Hold reset for a few edges with inputs toggling, then release straight into ADD 1+2.
    task automatic reset_phase();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            randomize_inputs();
            @(posedge clk);
            #1;
            check("reset_hold", {PSW, td}, 19'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        set_inputs(4'd0, 16'h0001, 16'h0002, 4'($urandom_range(0, 15)));
        exp_q.push_back({3'b000, 16'h0003});
        op_q.push_back(4'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [18:0] e;
        logic [3:0]  o;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = op_q.pop_front();
                check($sformatf("op%0d", o), {PSW, td}, e);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- main stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        randomize_inputs();
        #1;
        check("reset_async", {PSW, td}, 19'h0);
        reset_phase();

        //   op     A         B         s     PSW     td
        dir(4'd0,  16'hFFFF, 16'h0001, 4'd3, 3'b110, 16'h0000);  // ADD wrap
        dir(4'd0,  16'h7FFF, 16'h0001, 4'd0, 3'b001, 16'h8000);  // ADD overflow
        dir(4'd1,  16'h0003, 16'h0005, 4'd0, 3'b100, 16'hFFFE);  // SUB borrow
        dir(4'd1,  16'h8000, 16'h0001, 4'd0, 3'b001, 16'h7FFF);  // SUB overflow
        dir(4'd2,  16'hF0F0, 16'h0FF0, 4'd0, 3'b000, 16'h00F0);
        dir(4'd3,  16'h0000, 16'h0000, 4'd7, 3'b010, 16'h0000);
        dir(4'd4,  16'hAAAA, 16'hAAAA, 4'd0, 3'b010, 16'h0000);
        dir(4'd5,  16'hFFFF, 16'h1234, 4'd0, 3'b010, 16'h0000);
        dir(4'd8,  16'h8000, 16'h0000, 4'd4, 3'b000, 16'hF800);  // SRA sign fill
        dir(4'd8,  16'h4000, 16'h0000, 4'd1, 3'b000, 16'h2000);
        dir(4'd6,  16'h8001, 16'h0000, 4'd1, 3'b100, 16'h0002);  // SLL carry out
        dir(4'd6,  16'h0003, 16'h0000, 4'd15, 3'b100, 16'h8000);
        dir(4'd9,  16'h8001, 16'h0000, 4'd1, 3'b100, 16'h0003);  // ROL
        dir(4'd9,  16'h8001, 16'h0000, 4'd0, 3'b000, 16'h8001);  // ROL s=0
        dir(4'd10, 16'h0001, 16'h0000, 4'd1, 3'b100, 16'h8000);  // ROR
        dir(4'd7,  16'h1234, 16'hFFFF, 4'd0, 3'b000, 16'h1234);  // SRL s=0
        dir(4'd7,  16'h8001, 16'h0000, 4'd1, 3'b100, 16'h4000);
        dir(4'd7,  16'h8000, 16'h0000, 4'd15, 3'b000, 16'h0001);
        dir(4'd11, 16'hFFFF, 16'h0000, 4'd0, 3'b110, 16'h0000);  // INC wrap
        dir(4'd11, 16'h7FFF, 16'h5555, 4'd0, 3'b001, 16'h8000);  // INC overflow
        dir(4'd12, 16'h0000, 16'h0000, 4'd0, 3'b100, 16'hFFFF);  // DEC borrow
        dir(4'd12, 16'h8000, 16'h0000, 4'd0, 3'b001, 16'h7FFF);  // DEC overflow
        dir(4'd13, 16'hFFFF, 16'h0001, 4'd0, 3'b000, 16'h0001);  // SLT signed
        dir(4'd13, 16'h0001, 16'hFFFF, 4'd0, 3'b110, 16'h0000);
        dir(4'd14, 16'h0100, 16'h0100, 4'd0, 3'b110, 16'h0000);  // MUL high nonzero
        dir(4'd14, 16'h0003, 16'h0005, 4'd0, 3'b000, 16'h000F);
        dir(4'd15, 16'h1111, 16'hABCD, 4'd9, 3'b000, 16'hABCD);  // PASS

        // Mid-stream reset: outputs hold ABCD, then must clear without waiting for an edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_midstream", {PSW, td}, 19'h0);
        reset_phase();

        for (int i = 0; i < 1000; i++) rnd_op();

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu16.md
Name: alu16

Overview:
- 16-bit combinational-datapath ALU with registered result and status outputs.
- Each rising clock edge it samples a 4-bit operation code, two 16-bit operands and a 4-bit auxiliary field (the shift/rotate amount).
- It registers the 16-bit result `td` and a 3-bit status word `PSW`.
- It sits behind a register-file/RAM operand fetch stage in which operand indices are decoded from a 16-bit instruction word.

Parameters:
- WIDTH, 16, datapath width. Only 16 is required to be supported.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- Opcode  input  4  operation select
- alu_src1  input  16  operand A
- alu_src2  input  16  operand B
- Opcode_src3  input  4  shift/rotate amount, 0..15
- td  output  16  registered result
- PSW  output  3  registered status: PSW[2]=C (carry/borrow/shifted-out bit), PSW[1]=Z (zero), PSW[0]=V (signed overflow)

Behaviour:
- Reset: while rst=1, td=16'h0000 and PSW=3'b000, asynchronously and independent of clk. On release, the first rising edge loads a normal result.
- Latency: exactly 1 cycle.
  - Inputs are sampled at rising edge N; td/PSW show the result after edge N.
  - There is no handshake. A new operation is accepted every cycle, and outputs hold between edges.
- Operations (A=alu_src1, B=alu_src2, s=Opcode_src3, all arithmetic modulo 2^16):
  - 0 ADD: A+B. C=carry out of bit 15. V=signed overflow.
  - 1 SUB: A-B. C=borrow (1 when A<B unsigned). V=signed overflow.
  - 2 AND: A&B
  - 3 OR: A|B
  - 4 XOR: A^B
  - 5 NOT: ~A (B ignored)
  - 6 SLL: A<<s. C=last bit shifted out (bit 16-s of A). C=0 when s=0.
  - 7 SRL: A>>s, zero fill. C=bit s-1 of A. C=0 when s=0.
  - 8 SRA: A>>>s, sign fill. C=bit s-1 of A. C=0 when s=0.
  - 9 ROL: rotate A left by s. C=new bit 0 of result. C=0 when s=0.
  - 10 ROR: rotate A right by s. C=new bit 15 of result. C=0 when s=0.
  - 11 INC: A+1. C/V as ADD with B=1.
  - 12 DEC: A-1. C/V as SUB with B=1.
  - 13 SLT: td=16'h0001 if A<B signed, else 16'h0000. C=1 if A<B unsigned. V=0.
  - 14 MUL: low 16 bits of unsigned A*B. C=1 if the upper 16 bits of the 32-bit product are nonzero. V=0.
  - 15 PASS: td=B. C=0, V=0.
- Flags:
  - Z=1 exactly when the 16-bit result is 0, for every opcode.
  - C and V are 0 for every opcode not listed above as producing them (AND, OR, XOR, NOT and the non-arithmetic cases).
  - V for ADD/SUB/INC/DEC is computed from operand and result sign bits, not from a 17-bit compare.
- Operand rules:
  - Opcode_src3 is used only by opcodes 6-10 and ignored otherwise.
  - alu_src2 is ignored by opcodes 5-12.
- Inputs containing X/Z need not produce defined outputs.
- Reset asserted mid-stream:
  - Outputs clear immediately.
  - No operation is captured on an edge where rst=1.
  - No pending state exists beyond td/PSW.
- Implementation: one combinational case block feeding a single 19-bit output register. There is no other state.

Test Plan:
- Reset: assert rst with random inputs toggling -> td=0x0000, PSW=000 immediately and on every edge while asserted. Deassert, then ADD 0x0001+0x0002 -> td=0x0003, PSW=000 after the next edge.
- ADD wrap: A=0xFFFF, B=0x0001 -> td=0x0000, PSW=110. ADD overflow: A=0x7FFF, B=0x0001 -> td=0x8000, PSW=001.
- SUB borrow: A=0x0003, B=0x0005 -> td=0xFFFE, PSW=100. SUB overflow: A=0x8000, B=0x0001 -> td=0x7FFF, PSW=001.
- Shifts/rotates:
  - SRA A=0x8000, s=4 -> td=0xF800, PSW=000.
  - SLL A=0x8001, s=1 -> td=0x0002, C=1.
  - ROL A=0x8001, s=1 -> td=0x0003, C=1.
  - SRL with s=0 -> td=A, C=0.
- MUL/SLT:
  - MUL 0x0100*0x0100 -> td=0x0000, PSW=110.
  - SLT A=0xFFFF, B=0x0001 -> td=0x0001, C=0.
- Back-to-back random stream: new random Opcode/operands every cycle for 1000 cycles -> each cycle's td/PSW equals the reference model of the previous edge's inputs; never stalls.
